// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the neural-network layer control blocks.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SCAN  = 3'd2,
    HOLD  = 3'd3,
    ERROR = 3'd4
  } seq_state_t;

  // Neuron outputs are signed Q6.10 fixed point.
  localparam int dataIntWidth  = 6;
  localparam int dataFracWidth = 10;

  function automatic int idxBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_scanner.sv
// Sequential signed argmax: walks one neuron per cycle after a start pulse and
// reports the lowest index holding the maximum on its done cycle.
module argmax_scanner
  import nn_ctrl_pkg::*;
#(
  parameter int numNeurons = 16,
  parameter int dataWidth  = 16,
  parameter int idxWidth   = idxBits(numNeurons)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic                            clear_i,
  input  logic [dataWidth*numNeurons-1:0] vector_i,
  output logic                            done_o,
  output logic [idxWidth-1:0]             index_o
);

  localparam logic [idxWidth-1:0] lastPos = idxWidth'(numNeurons - 1);

  logic                        active_q, active_d;
  logic [idxWidth-1:0]         pos_q, pos_d;
  logic [idxWidth-1:0]         best_q, best_d;
  logic signed [dataWidth-1:0] max_q, max_d;
  logic signed [dataWidth-1:0] cand;

  assign cand = vector_i[int'(pos_q)*dataWidth +: dataWidth];

  // Strictly-greater update keeps the earliest index on ties.
  always_comb begin
    active_d = active_q;
    pos_d    = pos_q;
    best_d   = best_q;
    max_d    = max_q;
    if (clear_i) begin
      active_d = 1'b0;
      pos_d    = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      pos_d    = '0;
    end else if (active_q) begin
      if (pos_q == '0) begin
        max_d  = cand;
        best_d = '0;
      end else if (cand > max_q) begin
        max_d  = cand;
        best_d = pos_q;
      end
      if (pos_q == lastPos) begin
        active_d = 1'b0;
        pos_d    = '0;
      end else begin
        pos_d = pos_q + idxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      pos_q    <= '0;
      best_q   <= '0;
      max_q    <= '0;
    end else begin
      active_q <= active_d;
      pos_q    <= pos_d;
      best_q   <= best_d;
      max_q    <= max_d;
    end
  end

  assign done_o  = active_q && (pos_q == lastPos) && !clear_i;
  assign index_o = best_d;

endmodule

// File: rtl/layer_sequencer.sv
// Frame controller for one fully-connected layer: enables the layer, captures
// its outputs, picks the winning neuron and hands the result downstream.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int numInputs     = 784,
  parameter int numNeurons    = 16,
  parameter int dataWidth     = dataIntWidth + dataFracWidth,
  parameter int timeoutCycles = numInputs + 32,
  parameter int counterWidth  = $clog2(timeoutCycles + 1),
  parameter int idxWidth      = idxBits(numNeurons)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            abort,
  input  logic                            errClear,
  output logic                            layerEnable,
  input  logic                            layerDone,
  input  logic [dataWidth*numNeurons-1:0] layerResult,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [dataWidth*numNeurons-1:0] resultOut,
  output logic [idxWidth-1:0]             classIdx,
  output logic                            busy,
  output logic                            error
);

  localparam int gapWidth = $clog2(numNeurons + 1);
  localparam logic [gapWidth-1:0]     gapFull  = gapWidth'(numNeurons);
  localparam logic [counterWidth-1:0] cntLimit = counterWidth'(timeoutCycles);

  seq_state_t                      state_q, state_d;
  logic [counterWidth-1:0]         cycleCnt_q, cycleCnt_d;
  logic [gapWidth-1:0]             gapCnt_q, gapCnt_d;
  logic [dataWidth*numNeurons-1:0] resultOut_q, resultOut_d;
  logic [idxWidth-1:0]             classIdx_q, classIdx_d;

  logic                timeout;
  logic                scanStart;
  logic                scanClear;
  logic                scanDone;
  logic [idxWidth-1:0] scanIdx;

  assign timeout = (cycleCnt_q == cntLimit);

  // gapCnt counts cycles with the layer disabled; a new frame is only accepted
  // once the serializer has seen numNeurons+1 idle cycles, even after an abort.
  assign inReady     = (state_q == IDLE) && (gapCnt_q == gapFull);
  assign layerEnable = (state_q == RUN);
  assign outValid    = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign error       = (state_q == ERROR);
  assign resultOut   = resultOut_q;
  assign classIdx    = classIdx_q;

  assign scanStart = (state_q == RUN) && layerDone && !abort;
  assign scanClear = (state_q == SCAN) && abort;

  always_comb begin
    state_d     = state_q;
    cycleCnt_d  = '0;
    resultOut_d = resultOut_q;
    classIdx_d  = classIdx_q;
    gapCnt_d    = layerEnable ? '0 :
                  (gapCnt_q == gapFull) ? gapCnt_q : gapCnt_q + gapWidth'(1);
    case (state_q)
      IDLE: begin
        if (inValid && inReady) begin
          state_d    = RUN;
          cycleCnt_d = counterWidth'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (layerDone) begin
          state_d     = SCAN;
          resultOut_d = layerResult;
        end else if (timeout) begin
          state_d = ERROR;
        end else begin
          cycleCnt_d = cycleCnt_q + counterWidth'(1);
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (scanDone) begin
          state_d    = HOLD;
          classIdx_d = scanIdx;
        end
      end
      HOLD: begin
        if (abort || outReady) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (errClear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cycleCnt_q  <= '0;
      gapCnt_q    <= gapFull;
      resultOut_q <= '0;
      classIdx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycleCnt_q  <= cycleCnt_d;
      gapCnt_q    <= gapCnt_d;
      resultOut_q <= resultOut_d;
      classIdx_q  <= classIdx_d;
    end
  end

  argmax_scanner #(
    .numNeurons(numNeurons),
    .dataWidth (dataWidth),
    .idxWidth  (idxWidth)
  ) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .start_i (scanStart),
    .clear_i (scanClear),
    .vector_i(resultOut_q),
    .done_o  (scanDone),
    .index_o (scanIdx)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: frames are driven against a simulated
// layer, expected results queued, and a monitor checks every HOLD cycle.
module tb_layer_sequencer;

  localparam int numNeurons    = 16;
  localparam int dataWidth     = 16;
  localparam int timeoutCycles = 816;
  localparam int tot           = numNeurons * dataWidth;

  typedef struct {
    logic [tot-1:0] vec;
    int             idx;
    int             expCycle;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           inValid, inReady, abort, errClear;
  logic           layerEnable, layerDone;
  logic [tot-1:0] layerResult;
  logic           outValid, outReady;
  logic [tot-1:0] resultOut;
  logic [3:0]     classIdx;
  logic           busy, error;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fixedWait = -1;
  int   waitLeft;
  bit   headSeen = 0;
  exp_t sbQ[$];

  layer_sequencer dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .abort(abort), .errClear(errClear), .layerEnable(layerEnable),
    .layerDone(layerDone), .layerResult(layerResult), .outValid(outValid),
    .outReady(outReady), .resultOut(resultOut), .classIdx(classIdx),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL timeLimit actual=expired required=finish");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [tot-1:0] act,
                             input logic [tot-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: find the maximum signed value, then the lowest index holding it.
  function automatic int refArgmax(input logic [tot-1:0] v);
    logic signed [dataWidth-1:0] n;
    int maxVal;
    int best;
    maxVal = -100000;
    best   = -1;
    for (int i = 0; i < numNeurons; i++) begin
      n = v[i*dataWidth +: dataWidth];
      if (int'(n) > maxVal) maxVal = int'(n);
    end
    for (int i = 0; i < numNeurons; i++) begin
      n = v[i*dataWidth +: dataWidth];
      if (best < 0 && int'(n) == maxVal) best = i;
    end
    return best;
  endfunction

  function automatic logic [tot-1:0] randomVec();
    logic [tot-1:0] v;
    for (int i = 0; i < numNeurons; i++) v[i*dataWidth +: dataWidth] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [tot-1:0] tieVec();
    logic [tot-1:0] v;
    logic [15:0] pool [5];
    pool = '{16'hFF00, 16'h0100, 16'h0000, 16'h7FFF, 16'h8000};
    for (int i = 0; i < numNeurons; i++)
      v[i*dataWidth +: dataWidth] = pool[$urandom_range(0, 4)];
    return v;
  endfunction

  task automatic waitReady();
    int n;
    n = 0;
    while (!inReady && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("inReadyWait", tot'(inReady), tot'(1));
  endtask

  // abortMode: 0 none, 1 abort in RUN cycle abortAt, 2 abort abortAt cycles into
  // SCAN, 3 abort together with layerDone. runLen 0 means the layer never finishes.
  task automatic applyStimulus(input int runLen, input logic [tot-1:0] vec,
                               input int abortMode, input int abortAt);
    int enCount;
    int c;
    logic [tot-1:0] prevRes;
    waitReady();
    if (!inReady) return;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    enCount = 0;
    c = 1;
    while (layerEnable && c <= timeoutCycles + 4) begin
      enCount++;
      if (abortMode == 1 && c == abortAt) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abortRunBusy", tot'(busy), tot'(0));
        checkOutput("abortRunEnable", tot'(layerEnable), tot'(0));
        return;
      end
      if (c == runLen) begin
        prevRes     = resultOut;
        layerDone   = 1'b1;
        layerResult = vec;
        if (abortMode == 3) abort = 1'b1;
        if (abortMode == 0) begin
          sbQ.push_back('{vec: vec, idx: refArgmax(vec), expCycle: cyc + numNeurons + 1});
        end
        @(posedge clk); #1;
        layerDone   = 1'b0;
        abort       = 1'b0;
        layerResult = randomVec();
        checkOutput("enableLowAfterDone", tot'(layerEnable), tot'(0));
        if (abortMode == 3) begin
          checkOutput("abortDoneBusy", tot'(busy), tot'(0));
          checkOutput("abortDoneNoCapture", resultOut, prevRes);
          return;
        end
        checkOutput("enableCycles", tot'(enCount), tot'(runLen));
        checkOutput("noErrorAfterDone", tot'(error), tot'(0));
        if (abortMode == 2) begin
          repeat (abortAt - 1) begin @(posedge clk); #1; end
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          checkOutput("abortScanBusy", tot'(busy), tot'(0));
          checkOutput("abortScanOutValid", tot'(outValid), tot'(0));
        end
        return;
      end
      layerResult = randomVec();
      @(posedge clk); #1;
      c++;
    end
    checkOutput("timeoutEnableCycles", tot'(enCount), tot'(timeoutCycles));
    checkOutput("timeoutError", tot'(error), tot'(1));
    checkOutput("timeoutOutValid", tot'(outValid), tot'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("scoreboardDrained", tot'(sbQ.size()), tot'(0));
  endtask

  // Downstream sink: after each new result, hold outReady low for a while.
  initial begin
    outReady = 1'b0;
    waitLeft = 0;
    forever begin
      @(posedge clk); #1;
      if (outValid) begin
        if (waitLeft > 0) begin
          outReady = 1'b0;
          waitLeft--;
        end else begin
          outReady = 1'b1;
        end
      end else begin
        outReady = 1'b0;
        waitLeft = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 5));
      end
    end
  end

  // Monitor: every HOLD cycle is compared to the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && outValid) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spuriousOutValid actual=1 required=0");
      end else begin
        if (!headSeen) begin
          checkOutput("latency", tot'(cyc), tot'(sbQ[0].expCycle));
          headSeen = 1'b1;
        end
        checkOutput("resultOut", resultOut, sbQ[0].vec);
        checkOutput("classIdx", tot'(classIdx), tot'(sbQ[0].idx));
        checkOutput("inReadyInHold", tot'(inReady), tot'(0));
        if (outReady) begin
          void'(sbQ.pop_front());
          headSeen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [tot-1:0] v;
    reset = 1'b1; inValid = 1'b0; abort = 1'b0; errClear = 1'b0;
    layerDone = 1'b0; layerResult = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("resetInReady", tot'(inReady), tot'(1));
    checkOutput("resetBusy", tot'(busy), tot'(0));
    checkOutput("resetResultOut", resultOut, '0);
    checkOutput("resetClassIdx", tot'(classIdx), tot'(0));
    @(posedge clk); #1;

    $display("[TB] frame with neuron 5 winning, outReady held off 10 cycles");
    for (int i = 0; i < numNeurons; i++) v[i*dataWidth +: dataWidth] = 16'h0100;
    v[5*dataWidth +: dataWidth] = 16'h0A00;
    fixedWait = 10;
    applyStimulus(785, v, 0, 0);
    drain();
    fixedWait = -1;

    $display("[TB] reset asserted mid-RUN");
    waitReady();
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetInReady", tot'(inReady), tot'(1));
    checkOutput("midResetEnable", tot'(layerEnable), tot'(0));
    checkOutput("midResetOutValid", tot'(outValid), tot'(0));
    checkOutput("midResetError", tot'(error), tot'(0));
    checkOutput("midResetClassIdx", tot'(classIdx), tot'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] all-negative tie between neurons 3 and 9");
    for (int i = 0; i < numNeurons; i++) v[i*dataWidth +: dataWidth] = 16'(16'hF000 - i);
    v[3*dataWidth +: dataWidth] = 16'hFF00;
    v[9*dataWidth +: dataWidth] = 16'hFF00;
    applyStimulus(40, v, 0, 0);
    applyStimulus(1, tieVec(), 0, 0);
    drain();

    $display("[TB] aborts in RUN, SCAN and alongside layerDone");
    applyStimulus(50, randomVec(), 1, 20);
    applyStimulus(30, randomVec(), 2, 5);
    applyStimulus(25, randomVec(), 3, 0);
    applyStimulus(10, tieVec(), 0, 0);
    drain();

    $display("[TB] watchdog timeout and error recovery");
    applyStimulus(0, randomVec(), 0, 0);
    inValid = 1'b1;
    abort   = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("errorHeld", tot'(error), tot'(1));
    checkOutput("errorNoEnable", tot'(layerEnable), tot'(0));
    inValid  = 1'b0;
    errClear = 1'b1;
    @(posedge clk); #1;
    errClear = 1'b0;
    checkOutput("errClearBusy", tot'(busy), tot'(0));
    checkOutput("errClearError", tot'(error), tot'(0));
    checkOutput("errClearInReady", tot'(inReady), tot'(1));

    $display("[TB] layerDone on the timeout cycle");
    applyStimulus(timeoutCycles, randomVec(), 0, 0);
    drain();

    $display("[TB] randomized frames");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(int'($urandom_range(1, 120)), (k % 2 == 0) ? tieVec() : randomVec(), 0, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
